// File: rtl/mux_simples_pkg.sv
// Shared constants and helpers for the mux_simples data-select primitive.
package mux_simples_pkg;

    localparam int unsigned DEFAULT_WIDTH = 1;
    localparam int unsigned DEFAULT_CNT_W = 8;
    localparam int unsigned CALC_W        = 32;

    // Saturating increment: holds at max instead of wrapping.
    function automatic logic [CALC_W-1:0] sat_inc(
        input logic [CALC_W-1:0] count,
        input logic [CALC_W-1:0] max
    );
        return (count >= max) ? max : count + 32'd1;
    endfunction

endpackage

// File: rtl/mux_simples_mux2_core.sv
// Purely combinational 2:1 select: y = s ? b : a.
module mux2_core
    import mux_simples_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    // Same-cycle select; no X-masking on s.
    always_comb begin
        y = s ? b : a;
    end

endmodule

// File: rtl/mux_simples.sv
// 2:1 mux with combinational and registered outputs plus a select-activity
// monitor. Optional parity output y_par enabled by MUX_SIMPLES_PARITY_EN.
module mux_simples
    import mux_simples_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             sel_chg,
    output logic [CNT_W-1:0] sel_cnt
`ifdef MUX_SIMPLES_PARITY_EN
    ,
    output logic             y_par
`endif
);

    localparam logic [CALC_W-1:0] CNT_MAX = CALC_W'((64'd1 << CNT_W) - 64'd1);

    logic [WIDTH-1:0] data_d, data_q;
    logic             s_prev_d, s_prev_q;
    logic             sel_chg_d, sel_chg_q;
    logic [CNT_W-1:0] sel_cnt_d, sel_cnt_q;

    // Single select instance; the registered stage samples its output.
    mux2_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a (a),
        .b (b),
        .s (s),
        .y (y)
    );

    // Next-state: pipelined data, select history and saturating transition count.
    always_comb begin
        data_d    = y;
        s_prev_d  = s;
        sel_chg_d = (s != s_prev_q);
        sel_cnt_d = sel_cnt_q;
        if (sel_chg_d) begin
            sel_cnt_d = CNT_W'(sat_inc(CALC_W'(sel_cnt_q), CNT_MAX));
        end
    end

    // State registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q    <= '0;
            s_prev_q  <= 1'b0;
            sel_chg_q <= 1'b0;
            sel_cnt_q <= '0;
        end else begin
            data_q    <= data_d;
            s_prev_q  <= s_prev_d;
            sel_chg_q <= sel_chg_d;
            sel_cnt_q <= sel_cnt_d;
        end
    end

    assign y_q     = data_q;
    assign sel_chg = sel_chg_q;
    assign sel_cnt = sel_cnt_q;

`ifdef MUX_SIMPLES_PARITY_EN
    logic par_d, par_q;

    // Parity of the value being loaded into y_q, so both share one cycle of latency.
    always_comb begin
        par_d = ^data_d;
    end

    // Parity register, cleared with the rest of the pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign y_par = par_q;
`endif

endmodule

// File: tb/tb_mux_simples.sv
// Self-checking bench for mux_simples: directed steps followed by a
// randomized phase checked against a behavioural model.
`timescale 1ns/1ps
module tb_mux_simples;

    logic clk = 1'b0;
    logic reset;

    // Narrow instance: WIDTH=1, CNT_W=2 (truth table and saturation).
    logic       a1, b1, s1, y1, yq1, chg1;
    logic [1:0] cnt1;
    // Wide instance: WIDTH=8, CNT_W=8.
    logic [7:0] a8, b8, y8, yq8, cnt8;
    logic       s8, chg8;
`ifdef MUX_SIMPLES_PARITY_EN
    logic       par1, par8;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mux_simples #(.WIDTH(1), .CNT_W(2)) u_w1 (
        .clk     (clk),
        .reset   (reset),
        .a       (a1),
        .b       (b1),
        .s       (s1),
        .y       (y1),
        .y_q     (yq1),
        .sel_chg (chg1),
        .sel_cnt (cnt1)
`ifdef MUX_SIMPLES_PARITY_EN
        ,
        .y_par   (par1)
`endif
    );

    mux_simples #(.WIDTH(8), .CNT_W(8)) u_w8 (
        .clk     (clk),
        .reset   (reset),
        .a       (a8),
        .b       (b8),
        .s       (s8),
        .y       (y8),
        .y_q     (yq8),
        .sel_chg (chg8),
        .sel_cnt (cnt8)
`ifdef MUX_SIMPLES_PARITY_EN
        ,
        .y_par   (par8)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [7:0] tt;
        logic [7:0] pick8 [2];
        logic       pick1 [2];
        logic [7:0] e_yq8;
        logic       e_yq1, e_chg8, e_chg1;
        logic       m_prev8, m_prev1;
        int         m_cnt8, m_cnt1;

        a1 = 1'b0; b1 = 1'b0; s1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; s8 = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;

        // Reset state
        chk("rst_yq8",  32'(yq8),  32'h0);
        chk("rst_chg8", 32'(chg8), 32'h0);
        chk("rst_cnt8", 32'(cnt8), 32'h0);
        chk("rst_yq1",  32'(yq1),  32'h0);
        chk("rst_cnt1", 32'(cnt1), 32'h0);

        // Truth table (y is independent of reset): expected y for (a,b,s)=000..111
        tt = 8'b1101_1000;
        for (int i = 0; i < 8; i++) begin
            {a1, b1, s1} = 3'(i);
            #1;
            chk($sformatf("tt_%0d", i), 32'(y1), 32'(tt[i]));
        end

        a1 = 1'b0; b1 = 1'b0; s1 = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Latency: y immediate, y_q one cycle later
        a8 = 8'h3C; b8 = 8'hA5; s8 = 1'b0;
        #1;
        chk("lat_y_a", 32'(y8), 32'h3C);
        tick();
        chk("lat_yq_a", 32'(yq8), 32'h3C);
        chk("lat_chg0", 32'(chg8), 32'h0);
        s8 = 1'b1;
        #1;
        chk("lat_y_b", 32'(y8), 32'hA5);
        chk("lat_yq_hold", 32'(yq8), 32'h3C);
        tick();
        chk("lat_yq_b", 32'(yq8), 32'hA5);
        chk("lat_chg1", 32'(chg8), 32'h1);
        chk("lat_cnt1", 32'(cnt8), 32'h1);
        s8 = 1'b0;
        tick();
        s8 = 1'b1;
        tick();
        chk("pre_rst_yq", 32'(yq8), 32'hA5);
        chk("pre_rst_cnt", 32'(cnt8), 32'h3);

        // Reset pulse between edges
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_yq",  32'(yq8),  32'h0);
        chk("mid_rst_chg", 32'(chg8), 32'h0);
        chk("mid_rst_cnt", 32'(cnt8), 32'h0);
        chk("mid_rst_y",   32'(y8),   32'hA5);
        reset = 1'b0;

        // Select activity: first cycle with s=1 counts because history resets to 0
        for (int k = 0; k < 5; k++) begin
            s8 = (k % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            chk($sformatf("act_chg_%0d", k), 32'(chg8), 32'h1);
            chk($sformatf("act_cnt_%0d", k), 32'(cnt8), 32'(k + 1));
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("hold_chg_%0d", k), 32'(chg8), 32'h0);
            chk($sformatf("hold_cnt_%0d", k), 32'(cnt8), 32'h5);
        end

        // Saturation on the 2-bit counter
        for (int k = 0; k < 6; k++) begin
            s1 = ~s1;
            tick();
            chk($sformatf("sat_cnt_%0d", k), 32'(cnt1), 32'((k + 1 > 3) ? 3 : k + 1));
        end

        // Randomized phase against a behavioural model
        m_prev8 = 1'b1; m_cnt8 = 5;
        m_prev1 = 1'b0; m_cnt1 = 3;
        for (int n = 0; n < 600; n++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom_range(0, 1));
            a1 = 1'($urandom); b1 = 1'($urandom); s1 = 1'($urandom_range(0, 1));
            pick8[0] = a8; pick8[1] = b8;
            pick1[0] = a1; pick1[1] = b1;
            #1;
            chk("rnd_y8", 32'(y8), 32'(pick8[s8]));
            chk("rnd_y1", 32'(y1), 32'(pick1[s1]));
            e_yq8  = pick8[s8];
            e_yq1  = pick1[s1];
            e_chg8 = (s8 != m_prev8);
            e_chg1 = (s1 != m_prev1);
            if (e_chg8 && m_cnt8 < 255) m_cnt8++;
            if (e_chg1 && m_cnt1 < 3) m_cnt1++;
            m_prev8 = s8;
            m_prev1 = s1;
            tick();
            chk("rnd_yq8",  32'(yq8),  32'(e_yq8));
            chk("rnd_chg8", 32'(chg8), 32'(e_chg8));
            chk("rnd_cnt8", 32'(cnt8), 32'(m_cnt8));
            chk("rnd_yq1",  32'(yq1),  32'(e_yq1));
            chk("rnd_chg1", 32'(chg1), 32'(e_chg1));
            chk("rnd_cnt1", 32'(cnt1), 32'(m_cnt1));
`ifdef MUX_SIMPLES_PARITY_EN
            chk("rnd_par8", 32'(par8), 32'(^e_yq8));
`endif
        end
        chk("rnd_cnt8_sat", 32'(cnt8), 32'hFF);

`ifdef MUX_SIMPLES_PARITY_EN
        // Parity follows y_q with the same latency
        s8 = 1'b0; a8 = 8'h07;
        tick();
        chk("par_07", 32'(par8), 32'h1);
        a8 = 8'h03;
        tick();
        chk("par_03", 32'(par8), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux_simples.md
Name: mux_simples

Overview:
2:1 multiplexer with a combinational output and a registered copy of that output. It is the basic data-select primitive for datapath blocks that need both a same-cycle select and a pipelined select. A select-activity monitor counts select transitions for debug.

Parameters:
WIDTH, 1, bit width of data inputs a, b and outputs y, y_q
CNT_W, 8, width of the select-transition counter sel_cnt

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
a  input  WIDTH  data input, selected when s=0
b  input  WIDTH  data input, selected when s=1
s  input  1  select
y  output  WIDTH  combinational mux output
y_q  output  WIDTH  registered mux output
sel_chg  output  1  registered pulse: s differs from its previous sampled value
sel_cnt  output  CNT_W  saturating count of select transitions

Behaviour:
- One clock domain. Reset is asynchronous and active-high: on reset assertion, all registers clear immediately, independent of clk.
- y = s ? b : a. The path is purely combinational, so there is zero latency and the output settles within the same delta as the input change.
- y is not affected by reset and is valid whenever a, b and s are defined.
- y_q <= (s ? b : a) on each rising clk, giving 1-cycle latency. Reset value is all zeros.
- s_prev register samples s each cycle. Reset value of s_prev is 0.
- sel_chg <= (s != s_prev) on each cycle. Reset value is 0.
  - The first cycle after reset release with s=1 produces sel_chg=1, because s_prev resets to 0.
- sel_cnt increments by 1 on each cycle where s != s_prev.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - Reset value is 0.
- Reset asserted mid-operation:
  - y_q, sel_chg, sel_cnt and s_prev clear asynchronously.
  - y keeps tracking its inputs.
- Reset release: registers update starting at the first rising clk with reset low.
- X on s: y is X. No X-masking logic is provided.
- All widths are unsigned. No arithmetic on the data path.

Optional Feature:
Macro MUX_SIMPLES_PARITY_EN.
- Defined: adds output port y_par (1 bit) = XOR-reduction of y_q. It is registered alongside y_q, has the same 1-cycle latency, and its reset value is 0.
- Undefined: the y_par port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package mux_simples_pkg holds:
  - constants DEFAULT_WIDTH=1 and DEFAULT_CNT_W=8
  - function sat_inc(count, max) used for sel_cnt
- One sub-module, mux2_core: parameterized WIDTH, purely combinational, ports a, b, s, y.
  - It is instantiated once to drive y.
  - The registered stage in mux_simples samples its y.

Test Plan:
- Exhaustive truth table, WIDTH=1: step (a,b,s) through 000..111, 1 time unit each -> y = 0,0,0,1,1,0,1,1 respectively (y=a when s=0, y=b when s=1).
- Latency check, WIDTH=8: a=0x3C, b=0xA5, s=0 then s=1 at the next edge -> y changes immediately. y_q = 0x3C one cycle after the first edge and 0xA5 one cycle after s=1 is sampled.
- Reset mid-operation: with y_q=0xA5 and sel_cnt=3, pulse reset between clock edges -> y_q=0, sel_chg=0 and sel_cnt=0 immediately, while y still equals the selected input.
- Select activity: toggle s every cycle for 5 cycles after reset -> sel_chg=1 on each of those cycles and sel_cnt=5. Hold s constant -> sel_chg=0 and sel_cnt stays 5.
- Saturation, CNT_W=2: toggle s for 6 cycles -> sel_cnt reaches 3 and stays at 3.
- Parity, MUX_SIMPLES_PARITY_EN defined, WIDTH=8: select 0x07 -> y_par=1 one cycle later. Select 0x03 -> y_par=0.
